// File: rtl/gbt_elink_frame_rx.sv
// gbt_elink_frame_rx
// Receives one 16-bit GBT downlink elink word per 40 MHz cycle. Bits [15:12]
// are TTC strobes and are registered every cycle. Bits [11:0] carry a framed
// register request: header, ADDR_WORDS address words, DATA_WORDS data words
// and an end word. Each good frame produces a one-cycle request strobe.
//
// Ports
//   ttc_clk_40_i      40 MHz frame clock (sole clock)
//   reset_i           synchronous active-high reset
//   gbt_rx_data_i     received word: [15:12] TTC, [11:0] payload
//   req_en_o          one-cycle request strobe
//   req_we_o          1 = write, 0 = read (held until next request)
//   req_addr_o        request address (held until next request)
//   req_data_o        request write data (held until next request)
//   ttc_l1a_o, ttc_calpulse_o, ttc_resync_o, ttc_bc0_o
//                     registered copies of gbt_rx_data_i[15..12]
//   frame_err_o       one-cycle pulse when a frame is rejected
//   frame_err_cnt_o   saturating count of rejected frames
//   locked_o          high after LOCK_FRAMES consecutive good frames
module gbt_elink_frame_rx #(
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 32,
  parameter logic [11:0] FRAME_END   = 12'hABC,
  parameter bit          FRAME_CHECK = 1'b1,
  parameter int          LOCK_FRAMES = 4,
  parameter int          ERR_CNT_W   = 16
) (
  input  logic                 ttc_clk_40_i,
  input  logic                 reset_i,
  input  logic [15:0]          gbt_rx_data_i,
  output logic                 req_en_o,
  output logic                 req_we_o,
  output logic [ADDR_W-1:0]    req_addr_o,
  output logic [DATA_W-1:0]    req_data_o,
  output logic                 ttc_l1a_o,
  output logic                 ttc_calpulse_o,
  output logic                 ttc_resync_o,
  output logic                 ttc_bc0_o,
  output logic                 frame_err_o,
  output logic [ERR_CNT_W-1:0] frame_err_cnt_o,
  output logic                 locked_o
);

  localparam int ADDR_WORDS = (ADDR_W - 8 + 11) / 12;
  localparam int DATA_WORDS = (DATA_W + 11) / 12;
  localparam int ADDR_LO_W  = ADDR_W - 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_END
  } state_t;

  state_t state, state_nxt;

  logic [2:0]           word_cnt, word_cnt_nxt;
  logic [11:0]          payload;
  logic                 hdr_hit, shift_a, shift_d, frame_good, frame_bad;
  logic                 hdr_we;
  logic [7:0]           hdr_msb;
  logic [ADDR_LO_W-1:0] addr_sr;
  logic [DATA_W-1:0]    data_sr;
  logic [7:0]           good_cnt;

  assign payload  = gbt_rx_data_i[11:0];
  assign locked_o = (good_cnt == 8'(LOCK_FRAMES));

  always_comb begin
    state_nxt    = state;
    word_cnt_nxt = word_cnt;
    hdr_hit      = 1'b0;
    shift_a      = 1'b0;
    shift_d      = 1'b0;
    frame_good   = 1'b0;
    frame_bad    = 1'b0;
    case (state)
      S_IDLE: begin
        if (payload[11] && (payload[9:8] == 2'b00)) begin
          hdr_hit      = 1'b1;
          state_nxt    = S_ADDR;
          word_cnt_nxt = '0;
        end
      end
      S_ADDR: begin
        shift_a = 1'b1;
        if (word_cnt == 3'(ADDR_WORDS - 1)) begin
          state_nxt    = S_DATA;
          word_cnt_nxt = '0;
        end else begin
          word_cnt_nxt = word_cnt + 3'd1;
        end
      end
      S_DATA: begin
        shift_d = 1'b1;
        if (word_cnt == 3'(DATA_WORDS - 1)) begin
          state_nxt    = S_END;
          word_cnt_nxt = '0;
        end else begin
          word_cnt_nxt = word_cnt + 3'd1;
        end
      end
      S_END: begin
        // The end word always returns to IDLE; it is never itself re-parsed
        // as a header, so the next word is the first header candidate.
        if (!FRAME_CHECK || (payload == FRAME_END)) frame_good = 1'b1;
        else                                        frame_bad  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ttc_clk_40_i) begin
    if (reset_i) begin
      state    <= S_IDLE;
      word_cnt <= '0;
    end else begin
      state    <= state_nxt;
      word_cnt <= word_cnt_nxt;
    end
  end

  always_ff @(posedge ttc_clk_40_i) begin
    if (reset_i) begin
      ttc_l1a_o       <= 1'b0;
      ttc_calpulse_o  <= 1'b0;
      ttc_resync_o    <= 1'b0;
      ttc_bc0_o       <= 1'b0;
      req_en_o        <= 1'b0;
      req_we_o        <= 1'b0;
      req_addr_o      <= '0;
      req_data_o      <= '0;
      frame_err_o     <= 1'b0;
      frame_err_cnt_o <= '0;
      good_cnt        <= '0;
      hdr_we          <= 1'b0;
      hdr_msb         <= '0;
      addr_sr         <= '0;
      data_sr         <= '0;
    end else begin
      ttc_l1a_o      <= gbt_rx_data_i[15];
      ttc_calpulse_o <= gbt_rx_data_i[14];
      ttc_resync_o   <= gbt_rx_data_i[13];
      ttc_bc0_o      <= gbt_rx_data_i[12];
      req_en_o       <= frame_good;
      frame_err_o    <= frame_bad;

      if (hdr_hit) begin
        hdr_we  <= payload[10];
        hdr_msb <= payload[7:0];
      end
      // Shift registers keep only the low bits of the 12-bit word field;
      // upper pad bits fall off the top as later words arrive.
      if (shift_a) addr_sr <= ADDR_LO_W'({addr_sr, payload});
      if (shift_d) data_sr <= DATA_W'({data_sr, payload});

      if (frame_good) begin
        req_we_o   <= hdr_we;
        req_addr_o <= {hdr_msb, addr_sr};
        req_data_o <= data_sr;
        if (good_cnt != 8'(LOCK_FRAMES)) good_cnt <= good_cnt + 8'd1;
      end
      if (frame_bad) begin
        good_cnt <= '0;
        if (frame_err_cnt_o != '1) frame_err_cnt_o <= frame_err_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gbt_elink_frame_rx.sv
module tb_gbt_elink_frame_rx;

  typedef struct {
    bit              is_err;
    bit              we;
    longint unsigned addr;
    longint unsigned data;
    longint unsigned ecnt;
    bit              locked;
    longint unsigned due;
  } exp_t;

  logic             clk = 1'b0;
  logic [2:0]       rst;
  logic [2:0][15:0] din;
  logic [2:0][15:0] samp = '0;
  logic [2:0]       rst_s = '0;
  longint unsigned  cyc = 0;

  int tests = 0;
  int fails = 0;

  exp_t q0[$], q1[$], q2[$];
  int              m_good[3];
  longint unsigned m_err[3];
  bit              ttc_rand = 1'b0;
  logic [3:0]      ttc_fix  = 4'h0;

  // dut 0: defaults; dut 1: 4-word frame, small counters; dut 2: no end check
  logic en0, err0, we0, lk0; logic [31:0] ad0, da0; logic [15:0] ec0; logic [3:0] tt0;
  logic en1, err1, we1, lk1; logic [19:0] ad1; logic [7:0] da1; logic [1:0] ec1; logic [3:0] tt1;
  logic en2, err2, we2, lk2; logic [31:0] ad2, da2; logic [15:0] ec2; logic [3:0] tt2;

  gbt_elink_frame_rx #(.ADDR_W(32), .DATA_W(32)) u_a (
    .ttc_clk_40_i(clk), .reset_i(rst[0]), .gbt_rx_data_i(din[0]),
    .req_en_o(en0), .req_we_o(we0), .req_addr_o(ad0), .req_data_o(da0),
    .ttc_l1a_o(tt0[3]), .ttc_calpulse_o(tt0[2]), .ttc_resync_o(tt0[1]), .ttc_bc0_o(tt0[0]),
    .frame_err_o(err0), .frame_err_cnt_o(ec0), .locked_o(lk0));

  gbt_elink_frame_rx #(.ADDR_W(20), .DATA_W(8), .LOCK_FRAMES(2), .ERR_CNT_W(2)) u_b (
    .ttc_clk_40_i(clk), .reset_i(rst[1]), .gbt_rx_data_i(din[1]),
    .req_en_o(en1), .req_we_o(we1), .req_addr_o(ad1), .req_data_o(da1),
    .ttc_l1a_o(tt1[3]), .ttc_calpulse_o(tt1[2]), .ttc_resync_o(tt1[1]), .ttc_bc0_o(tt1[0]),
    .frame_err_o(err1), .frame_err_cnt_o(ec1), .locked_o(lk1));

  gbt_elink_frame_rx #(.FRAME_CHECK(1'b0)) u_c (
    .ttc_clk_40_i(clk), .reset_i(rst[2]), .gbt_rx_data_i(din[2]),
    .req_en_o(en2), .req_we_o(we2), .req_addr_o(ad2), .req_data_o(da2),
    .ttc_l1a_o(tt2[3]), .ttc_calpulse_o(tt2[2]), .ttc_resync_o(tt2[1]), .ttc_bc0_o(tt2[0]),
    .frame_err_o(err2), .frame_err_cnt_o(ec2), .locked_o(lk2));

  always #5 clk = ~clk;

  function automatic int AW(int id); return (id == 1) ? 20 : 32; endfunction
  function automatic int DW(int id); return (id == 1) ? 8 : 32; endfunction
  function automatic bit FC(int id); return (id != 2); endfunction
  function automatic int LF(int id); return (id == 1) ? 2 : 4; endfunction
  function automatic int EW(int id); return (id == 1) ? 2 : 16; endfunction

  task automatic cmp(string name, int id, longint unsigned got, longint unsigned exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s dut%0d got=0x%0h exp=0x%0h (cycle %0d)", name, id, got, exp, cyc);
    end
  endtask

  task automatic q_push(int id, exp_t e);
    case (id)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int q_size(int id);
    case (id)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic q_pop(int id, output exp_t e);
    case (id)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  always @(posedge clk) begin
    samp  <= din;
    rst_s <= rst;
    cyc   <= cyc + 1;
  end

  task automatic check(int id, logic en, logic err, logic we, longint unsigned ad,
                       longint unsigned da, longint unsigned ec, logic lk, logic [3:0] tt);
    exp_t e;
    if (rst_s[id]) begin
      cmp("reset_outputs", id, {en, err, we, lk, tt}, 0);
      cmp("reset_addr_data_cnt", id, ad | da | ec, 0);
      return;
    end
    cmp("ttc", id, tt, samp[id][15:12]);
    if (en || err) begin
      if (q_size(id) == 0) begin
        cmp("unexpected_strobe", id, {en, err}, 0);
      end else begin
        q_pop(id, e);
        cmp("strobe_kind", id, {en, err}, {!e.is_err, e.is_err});
        cmp("strobe_cycle", id, cyc, e.due);
        cmp("err_cnt", id, ec, e.ecnt);
        cmp("locked", id, lk, e.locked);
        if (!e.is_err) begin
          cmp("req_we", id, we, e.we);
          cmp("req_addr", id, ad, e.addr);
          cmp("req_data", id, da, e.data);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    check(0, en0, err0, we0, 64'(ad0), 64'(da0), 64'(ec0), lk0, tt0);
    check(1, en1, err1, we1, 64'(ad1), 64'(da1), 64'(ec1), lk1, tt1);
    check(2, en2, err2, we2, 64'(ad2), 64'(da2), 64'(ec2), lk2, tt2);
  end

  function automatic logic [3:0] ttc_bits();
    return ttc_rand ? 4'($urandom) : ttc_fix;
  endfunction

  task automatic send_word(int id, logic [15:0] w);
    din[id] = w;
    @(posedge clk);
    #1;
    din[id] = 16'h0000;
  endtask

  task automatic do_reset(logic [2:0] mask);
    rst = mask;
    @(posedge clk);
    #1;
    rst = '0;
    for (int i = 0; i < 3; i++)
      if (mask[i]) begin
        m_good[i] = 0;
        m_err[i]  = 0;
      end
  endtask

  // Encodes a request into frame words from its fields and predicts the
  // response from the frame rules.
  task automatic send_frame(int id, bit we, longint unsigned addr, longint unsigned data,
                            logic [11:0] endp, bit pad);
    int aw = AW(id), dw = DW(id);
    int na = (aw - 8 + 11) / 12, nd = (dw + 11) / 12;
    longint unsigned af, df, emax;
    exp_t e;
    addr = addr & ((64'd1 << aw) - 1);
    data = data & ((64'd1 << dw) - 1);
    af = addr & ((64'd1 << (aw - 8)) - 1);
    df = data;
    if (pad) begin
      af = af | ({$urandom, $urandom} << (aw - 8));
      df = df | ({$urandom, $urandom} << dw);
    end
    af = af & ((64'd1 << (na * 12)) - 1);
    df = df & ((64'd1 << (nd * 12)) - 1);
    send_word(id, {ttc_bits(), 1'b1, we, 2'b00, 8'((addr >> (aw - 8)) & 64'hFF)});
    for (int i = 0; i < na; i++)
      send_word(id, {ttc_bits(), 12'((af >> (12 * (na - 1 - i))) & 64'hFFF)});
    for (int i = 0; i < nd; i++)
      send_word(id, {ttc_bits(), 12'((df >> (12 * (nd - 1 - i))) & 64'hFFF)});
    e.is_err = !(!FC(id) || endp == 12'hABC);
    emax = (64'd1 << EW(id)) - 1;
    if (e.is_err) begin
      m_good[id] = 0;
      if (m_err[id] < emax) m_err[id]++;
    end else if (m_good[id] < LF(id)) begin
      m_good[id]++;
    end
    e.we     = we;
    e.addr   = addr;
    e.data   = data;
    e.ecnt   = m_err[id];
    e.locked = (m_good[id] == LF(id));
    e.due    = cyc + 1;
    q_push(id, e);
    send_word(id, {ttc_bits(), endp});
  endtask

  task automatic send_idle(int id);
    logic [15:0] w = 16'($urandom);
    if (w[11]) w[8] = 1'b1;
    send_word(id, w);
  endtask

  initial begin
    rst = '1;
    din = '0;
    for (int i = 0; i < 3; i++) begin m_good[i] = 0; m_err[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    rst = '0;

    // Reference frame, then same frame with a bad end word
    ttc_fix = 4'hF;
    send_frame(0, 1'b1, 64'h40000000, 64'h12345678, 12'hABC, 1'b0);
    send_word(0, 16'h0000);
    send_frame(0, 1'b1, 64'h40000000, 64'h12345678, 12'hABD, 1'b0);
    send_frame(2, 1'b1, 64'h40000000, 64'h12345678, 12'hABD, 1'b0);
    ttc_fix = 4'h0;

    // Lock: four good back to back, then one bad
    for (int i = 0; i < 4; i++)
      send_frame(0, 1'b1, 64'($urandom), 64'($urandom), 12'hABC, 1'b0);
    send_frame(0, 1'b0, 64'h1, 64'h2, 12'h123, 1'b0);

    // Read request; bad end word that looks like a header, then next frame
    send_frame(0, 1'b0, 64'h12ABCDEF, 64'h0, 12'hABC, 1'b0);
    send_frame(0, 1'b1, 64'h11111111, 64'h22222222, 12'hC40, 1'b0);
    send_frame(0, 1'b1, 64'h33333333, 64'h44444444, 12'hABC, 1'b0);

    // Narrow frame and error-counter saturation
    send_frame(1, 1'b1, 64'h55ABC, 64'hA5, 12'hABC, 1'b0);
    for (int i = 0; i < 5; i++)
      send_frame(1, 1'b1, 64'($urandom), 64'($urandom), 12'h000, 1'b0);

    // Reset after the data words of a frame, then a complete frame
    send_word(0, 16'hFC40);
    send_word(0, 16'hF000);
    send_word(0, 16'hF000);
    send_word(0, 16'hF012);
    send_word(0, 16'hF345);
    send_word(0, 16'hF678);
    do_reset(3'b001);
    send_frame(0, 1'b1, 64'h40000000, 64'h12345678, 12'hABC, 1'b0);

    // Randomized traffic across all three instances
    ttc_rand = 1'b1;
    for (int n = 0; n < 150; n++) begin
      int id = int'($urandom_range(2, 0));
      int idles = int'($urandom_range(2, 0));
      logic [11:0] endp = ($urandom_range(3, 0) == 0) ? 12'($urandom) : 12'hABC;
      for (int k = 0; k < idles; k++) send_idle(id);
      send_frame(id, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, endp, 1'b1);
    end

    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cmp("pending_expected", i, q_size(i), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
